// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//   Parametrised raster timing generator. A divider on the fast serial clock
//   produces a pixel-rate enable strobe and a registered divided pixel clock.
//   The enable steps the x/y raster counters, from which the sync, blanking
//   and line/frame marker outputs are decoded.
//
//   Optional feature macro: VIDEO_TIMING_FRAME_CNT_EN
//     defined   : frame_cnt counts completed frames, modulo 2^w_frame
//     undefined : frame_cnt is tied to zero and no counter register exists
//
// Ports
//   clk          in   fast clock (serial clock domain)
//   rst          in   synchronous reset, active-high
//   pixel_clk    out  divided clock, high for the upper half of each pixel
//   pixel_en     out  one-clk strobe, once per pixel (last divider phase)
//   hsync        out  horizontal sync, active level set by hsync_pol
//   vsync        out  vertical sync, active level set by vsync_pol
//   display_on   out  high inside the visible area
//   x            out  horizontal pixel counter
//   y            out  vertical line counter
//   line_start   out  high while x == 0
//   frame_start  out  high while x == 0 and y == 0
//   frame_cnt    out  completed frame counter
// -----------------------------------------------------------------------------
module video_timing_gen #(
    parameter int clk_div   = 5,
    parameter int h_active  = 640,
    parameter int h_front   = 16,
    parameter int h_sync    = 96,
    parameter int h_back    = 48,
    parameter int v_active  = 480,
    parameter int v_front   = 10,
    parameter int v_sync    = 2,
    parameter int v_back    = 33,
    parameter int hsync_pol = 0,
    parameter int vsync_pol = 0,
    parameter int w_frame   = 16,
    localparam int h_total  = h_active + h_front + h_sync + h_back,
    localparam int v_total  = v_active + v_front + v_sync + v_back,
    localparam int w_x      = $clog2(h_total),
    localparam int w_y      = $clog2(v_total)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               pixel_clk,
    output logic               pixel_en,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic [w_x-1:0]     x,
    output logic [w_y-1:0]     y,
    output logic               line_start,
    output logic               frame_start,
    output logic [w_frame-1:0] frame_cnt
);

    // A divider below 2 cannot produce a distinct high and low pixel_clk phase.
    generate
        if (clk_div < 2) begin : g_bad_div
            $error("video_timing_gen: clk_div must be >= 2");
        end
    endgenerate

    localparam int w_d = (clk_div > 2) ? $clog2(clk_div) : 1;

    localparam logic [w_d-1:0] d_last = w_d'(clk_div - 1);
    localparam logic [w_d-1:0] d_high = w_d'(clk_div - clk_div / 2);

    localparam logic [w_x-1:0] x_last = w_x'(h_total - 1);
    localparam logic [w_y-1:0] y_last = w_y'(v_total - 1);

    // Decode bounds carry one extra bit so a window ending exactly at the
    // total count does not overflow the counter width.
    localparam logic [w_x:0] h_act_c = (w_x + 1)'(h_active);
    localparam logic [w_x:0] hs_lo_c = (w_x + 1)'(h_active + h_front);
    localparam logic [w_x:0] hs_hi_c = (w_x + 1)'(h_active + h_front + h_sync);
    localparam logic [w_y:0] v_act_c = (w_y + 1)'(v_active);
    localparam logic [w_y:0] vs_lo_c = (w_y + 1)'(v_active + v_front);
    localparam logic [w_y:0] vs_hi_c = (w_y + 1)'(v_active + v_front + v_sync);

    localparam logic h_pol = (hsync_pol != 0) ? 1'b1 : 1'b0;
    localparam logic v_pol = (vsync_pol != 0) ? 1'b1 : 1'b0;

    logic [w_d-1:0] d_r;
    logic [w_d-1:0] d_next_s;
    logic [w_x-1:0] x_next_s;
    logic [w_y-1:0] y_next_s;
    logic           hsync_next_s;
    logic           vsync_next_s;
    logic           display_next_s;
    logic           line_next_s;
    logic           frame_next_s;
    logic           hs_act_s;
    logic           vs_act_s;

    // Divider phase and raster counter next-state.
    always_comb begin
        d_next_s = d_r;
        x_next_s = x;
        y_next_s = y;
        if (d_r == d_last) begin
            d_next_s = '0;
        end else begin
            d_next_s = d_r + w_d'(1);
        end
        if (pixel_en) begin
            if (x == x_last) begin
                x_next_s = '0;
                if (y == y_last) begin
                    y_next_s = '0;
                end else begin
                    y_next_s = y + w_y'(1);
                end
            end else begin
                x_next_s = x + w_x'(1);
                y_next_s = y;
            end
        end else begin
            x_next_s = x;
            y_next_s = y;
        end
    end

    // Decode sync, blanking and markers from the next counter values so the
    // registered outputs change on the same edge as x/y.
    always_comb begin
        hs_act_s       = ({1'b0, x_next_s} >= hs_lo_c) && ({1'b0, x_next_s} < hs_hi_c);
        vs_act_s       = ({1'b0, y_next_s} >= vs_lo_c) && ({1'b0, y_next_s} < vs_hi_c);
        hsync_next_s   = h_pol ? hs_act_s : ~hs_act_s;
        vsync_next_s   = v_pol ? vs_act_s : ~vs_act_s;
        display_next_s = ({1'b0, x_next_s} < h_act_c) && ({1'b0, y_next_s} < v_act_c);
        line_next_s    = (x_next_s == '0);
        frame_next_s   = (x_next_s == '0) && (y_next_s == '0);
    end

    // Divider, strobes, counters and decoded outputs. Decoded outputs only
    // move on pixel edges, so they hold their reset values until the first
    // pixel_en has been consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_r         <= '0;
            pixel_en    <= 1'b0;
            pixel_clk   <= 1'b0;
            x           <= '0;
            y           <= '0;
            hsync       <= ~h_pol;
            vsync       <= ~v_pol;
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            d_r       <= d_next_s;
            pixel_en  <= (d_next_s == d_last);
            pixel_clk <= (d_next_s >= d_high);
            x         <= x_next_s;
            y         <= y_next_s;
            if (pixel_en) begin
                hsync       <= hsync_next_s;
                vsync       <= vsync_next_s;
                display_on  <= display_next_s;
                line_start  <= line_next_s;
                frame_start <= frame_next_s;
            end
        end
    end

`ifdef VIDEO_TIMING_FRAME_CNT_EN
    logic               frame_wrap_s;
    logic [w_frame-1:0] frame_cnt_r;

    // A frame completes on the pixel edge where both counters wrap.
    always_comb begin
        frame_wrap_s = pixel_en && (x == x_last) && (y == y_last);
    end

    // Completed-frame counter, wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r <= '0;
        end else if (frame_wrap_s) begin
            frame_cnt_r <= frame_cnt_r + w_frame'(1);
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`else
    assign frame_cnt = '0;
`endif

endmodule
